// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: holds the PLL in reset, qualifies lock, then releases domain resets in order.
// Optional lock-loss counter is built only when PLL_SEQ_LOSS_COUNT_EN is defined.
module pll_reset_sequencer #(
   parameter int NUM_DOMAINS    = 5,
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 65535,
   parameter int STABLE_CYCLES  = 1024,
   parameter int STAGE_GAP      = 8,
   parameter int MAX_RETRIES    = 3,
   parameter int CNT_W          = 16
) (
   input  logic                   refclk,
   input  logic                   rst,
   input  logic                   pll_locked,
   input  logic                   relock_req,
   output logic                   pll_rst,
   output logic [NUM_DOMAINS-1:0] domain_rst,
   output logic                   ready,
   output logic                   fault,
   output logic [2:0]             state,
   output logic [7:0]             lock_loss_cnt
);

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      SETTLE    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4,
      FAULT     = 3'd5
   } st_t;

   localparam int RTY_W = $clog2(MAX_RETRIES + 1);
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] REL_LAST = CNT_W'((NUM_DOMAINS - 1) * STAGE_GAP);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

   st_t                   cur_st, nxt_st;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [RTY_W-1:0]      rty, rty_nxt;
   logic                  sync1, locked_s;
   logic                  loss;
   logic                  pll_rst_nxt, ready_nxt, fault_nxt;
   logic [NUM_DOMAINS-1:0] drst_nxt;

   always_comb begin
      nxt_st  = cur_st;
      cnt_nxt = cnt + 1'b1;
      rty_nxt = rty;
      loss    = (cur_st == RELEASE || cur_st == RUN) && !locked_s;
      case (cur_st)
         RESET_PLL: if (cnt == RST_LAST) begin
            nxt_st  = WAIT_LOCK;
            cnt_nxt = '0;
         end
         WAIT_LOCK: if (locked_s) begin
            nxt_st  = SETTLE;
            cnt_nxt = '0;
         end else if (cnt == TMO_LAST) begin
            rty_nxt = rty + 1'b1;
            cnt_nxt = '0;
            nxt_st  = (rty_nxt == RTY_MAX) ? FAULT : RESET_PLL;
         end
         SETTLE: if (!locked_s) begin
            nxt_st  = WAIT_LOCK;
            cnt_nxt = '0;
         end else if (cnt == STB_LAST) begin
            nxt_st  = RELEASE;
            cnt_nxt = '0;
         end
         RELEASE: if (cnt == REL_LAST) begin
            nxt_st  = RUN;
            cnt_nxt = '0;
            rty_nxt = '0;
         end
         RUN:     cnt_nxt = '0;
         FAULT:   cnt_nxt = '0;
         default: begin
            nxt_st  = RESET_PLL;
            cnt_nxt = '0;
         end
      endcase
      if (loss) begin
         nxt_st  = RESET_PLL;
         cnt_nxt = '0;
      end
      if (relock_req) begin
         nxt_st  = RESET_PLL;
         cnt_nxt = '0;
         rty_nxt = '0;
      end
      pll_rst_nxt = (nxt_st == RESET_PLL) || (nxt_st == FAULT);
      ready_nxt   = (nxt_st == RUN);
      fault_nxt   = (nxt_st == FAULT);
   end

   // Bit i is released once the RELEASE counter reaches i*STAGE_GAP; any other state holds all bits.
   for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
      if (i == 0) begin : g_first
         assign drst_nxt[i] = !(nxt_st == RUN || nxt_st == RELEASE);
      end else begin : g_rest
         localparam logic [CNT_W-1:0] STG = CNT_W'(i * STAGE_GAP);
         assign drst_nxt[i] = !(nxt_st == RUN || (nxt_st == RELEASE && cnt_nxt >= STG));
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         cur_st     <= RESET_PLL;
         cnt        <= '0;
         rty        <= '0;
         sync1      <= 1'b0;
         locked_s   <= 1'b0;
         pll_rst    <= 1'b1;
         domain_rst <= '1;
         ready      <= 1'b0;
         fault      <= 1'b0;
      end else begin
         cur_st     <= nxt_st;
         cnt        <= cnt_nxt;
         rty        <= rty_nxt;
         sync1      <= pll_locked;
         locked_s   <= sync1;
         pll_rst    <= pll_rst_nxt;
         domain_rst <= drst_nxt;
         ready      <= ready_nxt;
         fault      <= fault_nxt;
      end
   end

   assign state = cur_st;

`ifdef PLL_SEQ_LOSS_COUNT_EN
   always_ff @(posedge refclk) begin
      if (rst)
         lock_loss_cnt <= '0;
      else if (loss && lock_loss_cnt != 8'hFF)
         lock_loss_cnt <= lock_loss_cnt + 1'b1;
   end
`else
   assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: directed scenarios push cycle-tagged expectations,
// a negedge monitor checks them against the DUT outputs.
module tb_pll_reset_sequencer;

   localparam int ND = 5;

   logic          refclk = 1'b0;
   logic          rst = 1'b1;
   logic          pll_locked = 1'b0;
   logic          relock_req = 1'b0;
   logic          pll_rst;
   logic [ND-1:0] domain_rst;
   logic          ready;
   logic          fault;
   logic [2:0]    state;
   logic [7:0]    lock_loss_cnt;

   pll_reset_sequencer #(
      .NUM_DOMAINS(ND), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8),
      .STAGE_GAP(3), .MAX_RETRIES(2), .CNT_W(16)
   ) dut (
      .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .relock_req(relock_req),
      .pll_rst(pll_rst), .domain_rst(domain_rst), .ready(ready), .fault(fault),
      .state(state), .lock_loss_cnt(lock_loss_cnt)
   );

   always #5 refclk = ~refclk;

   localparam int P = 0, D = 1, R = 2, F = 3, S = 4, L = 5;
   localparam int LIMIT = 40000;

   typedef struct {
      int          cyc;
      int          id;
      logic [31:0] val;
      string       nm;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   base = 0;
   int   checks = 0;
   int   failures = 0;
   bit   done = 1'b0;

   always @(posedge refclk) cyc <= cyc + 1;

   function automatic logic [31:0] actual(int id);
      case (id)
         P:       return {31'b0, pll_rst};
         D:       return 32'(domain_rst);
         R:       return {31'b0, ready};
         F:       return {31'b0, fault};
         S:       return 32'(state);
         default: return 32'(lock_loss_cnt);
      endcase
   endfunction

   // Monitor: compare every expectation tagged for the current cycle; stale ones count as missed.
   always @(negedge refclk) begin
      logic [31:0] act;
      for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
         if (sb[i].cyc <= cyc) begin
            act = actual(sb[i].id);
            checks++;
            if (sb[i].cyc < cyc) begin
               failures++;
               $display("FAIL %s missed at cyc=%0d (now %0d)", sb[i].nm, sb[i].cyc, cyc);
            end else if (act !== sb[i].val) begin
               failures++;
               $display("FAIL %s cyc=%0d got=%0h exp=%0h", sb[i].nm, cyc, act, sb[i].val);
            end
            sb.delete(i);
         end
      end
      if (cyc > LIMIT && !done) begin
         checks++;
         failures++;
         $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   task automatic ex(int k, int id, logic [31:0] v, string nm);
      sb.push_back('{base + k, id, v, nm});
   endtask

   task automatic at(int k);
      while (cyc < base + k) @(negedge refclk);
   endtask

   // Assert reset; base is the cycle in which rst will first be sampled low (cycle 0).
   task automatic begin_reset();
      @(negedge refclk);
      rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;
      repeat (2) @(negedge refclk);
      base = cyc + 1;
   endtask

   task automatic end_reset();
      @(negedge refclk);
      rst = 1'b0;
   endtask

   initial begin
      // Nominal bring-up
      begin_reset();
      ex(0, S, 0, "nom_rst_state"); ex(0, P, 1, "nom_rst_pll");  ex(0, D, 'h1F, "nom_rst_drst");
      ex(0, R, 0, "nom_rst_ready"); ex(0, F, 0, "nom_rst_fault"); ex(0, L, 0, "nom_rst_llc");
      ex(3, P, 1, "nom_pll_hi3");   ex(4, P, 0, "nom_pll_lo4");  ex(4, S, 1, "nom_wait");
      ex(12, S, 1, "nom_wait12");   ex(13, S, 2, "nom_settle");
      ex(20, D, 'h1F, "nom_d20");   ex(20, S, 2, "nom_s20");
      ex(21, D, 'h1E, "nom_d21");   ex(21, S, 3, "nom_release");
      ex(24, D, 'h1C, "nom_d24");   ex(27, D, 'h18, "nom_d27");  ex(30, D, 'h10, "nom_d30");
      ex(33, D, 'h00, "nom_d33");   ex(33, R, 0, "nom_r33");
      ex(34, R, 1, "nom_ready");    ex(34, S, 4, "nom_run");
      end_reset();
      at(10); pll_locked = 1'b1;
      at(36);

      // Settle glitch: one-cycle drop at the 5th SETTLE cycle
      begin_reset();
      ex(13, S, 2, "gl_s13"); ex(18, S, 2, "gl_s18"); ex(19, S, 2, "gl_s19");
      ex(20, S, 1, "gl_back_wait"); ex(20, D, 'h1F, "gl_d20"); ex(21, S, 2, "gl_resettle");
      ex(28, S, 2, "gl_s28"); ex(28, D, 'h1F, "gl_d28");
      ex(29, S, 3, "gl_release"); ex(29, D, 'h1E, "gl_d29");
      ex(41, D, 'h00, "gl_d41"); ex(41, R, 0, "gl_r41");
      ex(42, R, 1, "gl_ready"); ex(42, S, 4, "gl_run");
      end_reset();
      at(10); pll_locked = 1'b1;
      at(17); pll_locked = 1'b0;
      at(18); pll_locked = 1'b1;
      at(43);

      // Timeout to fault, then relock
      begin_reset();
      ex(3, P, 1, "to_p3"); ex(4, P, 0, "to_p4"); ex(4, S, 1, "to_s4");
      ex(23, S, 1, "to_s23"); ex(23, P, 0, "to_p23");
      ex(24, S, 0, "to_retry1"); ex(24, P, 1, "to_p24");
      ex(27, S, 0, "to_s27"); ex(27, P, 1, "to_p27");
      ex(28, S, 1, "to_s28"); ex(28, P, 0, "to_p28");
      ex(47, S, 1, "to_s47"); ex(47, F, 0, "to_f47");
      ex(48, S, 5, "to_fault_state"); ex(48, F, 1, "to_fault"); ex(48, P, 1, "to_fault_pll");
      ex(48, D, 'h1F, "to_fault_drst");
      ex(60, S, 5, "to_s60"); ex(60, F, 1, "to_f60");
      ex(61, S, 0, "to_relock"); ex(61, F, 0, "to_fault_clr"); ex(61, P, 1, "to_p61");
      ex(64, P, 1, "to_p64"); ex(65, P, 0, "to_p65"); ex(65, S, 1, "to_s65");
      ex(84, S, 1, "to_s84"); ex(85, S, 0, "to_retry_cleared"); ex(85, F, 0, "to_f85");
      end_reset();
      at(60); relock_req = 1'b1;
      at(61); relock_req = 1'b0;
      at(86);

      // Relock during RELEASE
      begin_reset();
      ex(24, D, 'h1C, "rl_d24"); ex(25, D, 'h1C, "rl_d25");
      ex(26, D, 'h1F, "rl_d26"); ex(26, S, 0, "rl_s26"); ex(26, P, 1, "rl_p26");
      ex(26, L, 0, "rl_llc"); ex(26, R, 0, "rl_r26");
      ex(29, S, 0, "rl_s29"); ex(30, S, 1, "rl_s30"); ex(31, S, 2, "rl_s31");
      ex(38, D, 'h1F, "rl_d38"); ex(39, D, 'h1E, "rl_d39"); ex(39, S, 3, "rl_s39");
      end_reset();
      at(10); pll_locked = 1'b1;
      at(25); relock_req = 1'b1;
      at(26); relock_req = 1'b0;
      at(40);

      // rst mid-RELEASE, then full replay
      begin_reset();
      ex(27, D, 'h18, "mr_d27"); ex(27, S, 3, "mr_s27");
      ex(28, S, 0, "mr_s28"); ex(28, D, 'h1F, "mr_d28"); ex(28, P, 1, "mr_p28");
      ex(28, R, 0, "mr_r28"); ex(28, F, 0, "mr_f28"); ex(28, L, 0, "mr_l28");
      ex(31, P, 1, "mr_p31"); ex(32, P, 0, "mr_p32");
      ex(48, D, 'h1F, "mr_d48"); ex(49, D, 'h1E, "mr_d49");
      ex(61, D, 'h00, "mr_d61"); ex(62, R, 1, "mr_ready"); ex(62, S, 4, "mr_run");
      end_reset();
      at(10); pll_locked = 1'b1;
      at(27); rst = 1'b1; pll_locked = 1'b0;
      at(28); rst = 1'b0;
      at(38); pll_locked = 1'b1;
      at(64);

      // Loss in RUN, repeated to saturate the loss counter
      begin_reset();
      end_reset();
      for (int n = 1; n <= 300; n++) begin
         logic [31:0] llc_exp;
`ifdef PLL_SEQ_LOSS_COUNT_EN
         llc_exp = (n > 255) ? 32'd255 : 32'(n);
`else
         llc_exp = 32'd0;
`endif
         ex(36, R, 1, "ll_ready");
         ex(37, S, 0, "ll_state"); ex(37, D, 'h1F, "ll_drst"); ex(37, R, 0, "ll_ready_lo");
         ex(37, L, llc_exp, "ll_cnt");
         at(10); pll_locked = 1'b1;
         at(34); pll_locked = 1'b0;
         at(37);
         base = base + 37;
      end

      repeat (3) @(negedge refclk);
      done = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
